// File: rtl/ram_write_sequencer_if.sv
// Control, RAM write port and status signals of the RAM write-pattern sequencer.
interface ram_write_sequencer_if #(
   parameter int unsigned NUM_WORDS = 4,
   parameter int unsigned WORD_W    = 16,
   parameter int unsigned ADDR_W    = 14
);
   logic                          i_enable;
   logic [15:0]                   i_interval;
   logic [15:0]                   i_burst_len;
   logic                          i_ram_ready;
   logic                          o_wr_en;
   logic [ADDR_W-1:0]             o_addr;
   logic [NUM_WORDS*WORD_W-1:0]   o_data;
   logic                          o_wrap;
   logic                          o_done;
   logic                          o_busy;
   logic [31:0]                   o_write_count;

   // Sequencer side.
   modport master (
      input  i_enable, i_interval, i_burst_len, i_ram_ready,
      output o_wr_en, o_addr, o_data, o_wrap, o_done, o_busy, o_write_count
   );

   // Controller / RAM side.
   modport slave (
      output i_enable, i_interval, i_burst_len, i_ram_ready,
      input  o_wr_en, o_addr, o_data, o_wrap, o_done, o_busy, o_write_count
   );
endinterface

// File: rtl/ram_write_sequencer.sv
// Periodic multi-word RAM write generator with ready/valid backpressure,
// start delay, inter-write gap, burst/free-run modes and wrap/done pulses.
module ram_write_sequencer #(
   parameter int unsigned NUM_WORDS   = 4,
   parameter int unsigned WORD_W      = 16,
   parameter int unsigned ADDR_W      = 14,
   parameter int unsigned START_DELAY = 4,
   parameter int unsigned WRAP_TO     = 1
) (
   input logic                   i_clk,
   input logic                   i_rst,
   ram_write_sequencer_if.master bus
);

   localparam int unsigned DATA_W = NUM_WORDS * WORD_W;

   typedef enum logic [1:0] {StIdle, StInit, StWrite, StWait} state_e;

   state_e              state_q, state_d;
   logic [31:0]         dly_cnt_q, dly_cnt_d;
   logic [15:0]         gap_cnt_q, gap_cnt_d;
   logic [15:0]         interval_q, interval_d;
   logic [15:0]         burst_len_q, burst_len_d;
   logic [15:0]         burst_cnt_q, burst_cnt_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                wrap_q, wrap_d;
   logic                done_q, done_d;
   logic [31:0]         write_count_q, write_count_d;

   logic                start;
   logic                issue;
   logic                accept;
   logic                burst_end;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the per-edge events that drive the datapath.
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      issue     = 1'b0;
      accept    = 1'b0;
      burst_end = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.i_enable) begin
               start   = 1'b1;
               state_d = StInit;
            end
         end
         StInit: begin
            // Counter starts at 0 the cycle after enable is sampled, so the
            // strict compare puts the first issue START_DELAY+2 edges after it.
            if (!bus.i_enable) begin
               state_d = StIdle;
            end else if (dly_cnt_q > START_DELAY) begin
               issue   = 1'b1;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (bus.i_ram_ready) begin
               accept = 1'b1;
               if ((burst_len_q != 16'd0) && ((burst_cnt_q + 16'd1) == burst_len_q)) begin
                  burst_end = 1'b1;
                  state_d   = StIdle;
               end else if (!bus.i_enable) begin
                  state_d = StIdle;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (!bus.i_enable) begin
               state_d = StIdle;
            end else if (({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, interval_q}) begin
               issue   = 1'b1;
               state_d = StWrite;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: counters, address/data pattern and status pulses.
   always_comb begin
      dly_cnt_d     = dly_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      interval_d    = interval_q;
      burst_len_d   = burst_len_q;
      burst_cnt_d   = burst_cnt_q;
      wr_en_d       = wr_en_q;
      addr_d        = addr_q;
      data_d        = data_q;
      wrap_d        = 1'b0;
      done_d        = burst_end;
      write_count_d = write_count_q;

      if (start) begin
         dly_cnt_d   = '0;
         burst_cnt_d = '0;
         burst_len_d = bus.i_burst_len;
      end
      if ((state_q == StInit) && !issue) begin
         dly_cnt_d = dly_cnt_q + 32'd1;
      end
      if ((state_q == StWait) && !issue) begin
         gap_cnt_d = gap_cnt_q + 16'd1;
      end
      if (issue) begin
         wr_en_d = 1'b1;
         wrap_d  = (addr_q == '1);
         addr_d  = (addr_q == '1) ? ADDR_W'(WRAP_TO) : addr_q + ADDR_W'(1);
         for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            data_d[k*WORD_W +: WORD_W] = data_q[k*WORD_W +: WORD_W] + WORD_W'(NUM_WORDS);
         end
      end
      if (accept) begin
         wr_en_d       = 1'b0;
         write_count_d = write_count_q + 32'd1;
         burst_cnt_d   = burst_cnt_q + 16'd1;
         interval_d    = (bus.i_interval == 16'd0) ? 16'd1 : bus.i_interval;
         gap_cnt_d     = '0;
      end
   end

   // Datapath registers; reset restarts the address/data sequence.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dly_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         interval_q    <= 16'd1;
         burst_len_q   <= '0;
         burst_cnt_q   <= '0;
         wr_en_q       <= 1'b0;
         addr_q        <= '0;
         for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            data_q[k*WORD_W +: WORD_W] <= WORD_W'(k);
         end
         wrap_q        <= 1'b0;
         done_q        <= 1'b0;
         write_count_q <= '0;
      end else begin
         dly_cnt_q     <= dly_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         interval_q    <= interval_d;
         burst_len_q   <= burst_len_d;
         burst_cnt_q   <= burst_cnt_d;
         wr_en_q       <= wr_en_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         wrap_q        <= wrap_d;
         done_q        <= done_d;
         write_count_q <= write_count_d;
      end
   end

   // Outputs straight from registers; busy decoded from state.
   always_comb begin
      bus.o_wr_en       = wr_en_q;
      bus.o_addr        = addr_q;
      bus.o_data        = data_q;
      bus.o_wrap        = wrap_q;
      bus.o_done        = done_q;
      bus.o_busy        = (state_q != StIdle);
      bus.o_write_count = write_count_q;
   end

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Scoreboard bench: stimulus pushes predicted writes, a negedge monitor pops
// and compares each write as it appears on the port.
module tb_ram_write_sequencer;

   localparam int unsigned NW   = 4;
   localparam int unsigned WW   = 8;
   localparam int unsigned AW   = 5;
   localparam int unsigned SD   = 4;
   localparam int unsigned WT   = 1;
   localparam int unsigned DW   = NW * WW;
   localparam int unsigned AMAX = (1 << AW) - 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          wrap;
      int            gap;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_write_sequencer_if #(.NUM_WORDS(NW), .WORD_W(WW), .ADDR_W(AW)) bus ();

   ram_write_sequencer #(
      .NUM_WORDS   (NW),
      .WORD_W      (WW),
      .ADDR_W      (AW),
      .START_DELAY (SD),
      .WRAP_TO     (WT)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   n_exp = 0;
   int   done_exp = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // n-th write since reset: addresses 1..all-ones, then WT..all-ones repeating.
   function automatic logic [AW-1:0] m_addr(input int unsigned n);
      int unsigned period = AMAX - WT + 1;
      if (n <= AMAX) return AW'(n);
      return AW'(WT + ((n - AMAX - 1) % period));
   endfunction

   function automatic logic m_wrap(input int unsigned n);
      int unsigned period = AMAX - WT + 1;
      return (n > AMAX) && (((n - AMAX - 1) % period) == 0);
   endfunction

   function automatic logic [DW-1:0] m_data(input int unsigned n);
      logic [DW-1:0] d;
      for (int unsigned k = 0; k < NW; k++) d[k*WW +: WW] = WW'((n * NW + k) % (1 << WW));
      return d;
   endfunction

   task automatic push_writes(input int count, input int gap);
      exp_t e;
      for (int i = 0; i < count; i++) begin
         n_exp++;
         e.addr = m_addr(n_exp);
         e.data = m_data(n_exp);
         e.wrap = m_wrap(n_exp);
         e.gap  = gap;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: inputs change at posedge+2, so at negedge ready is what the next edge samples.
   logic prev_wr = 1'b0, prev_acc = 1'b0, first_pending = 1'b0, have_cur = 1'b0;
   int   low_cnt = 0, cyc = 0, start_cyc = 0;
   exp_t cur;
   always @(negedge clk) begin
      logic new_wr;
      if (rst) begin
         prev_wr = 1'b0; prev_acc = 1'b0; first_pending = 1'b0; have_cur = 1'b0;
         low_cnt = 0;
         exp_q.delete();
      end else begin
         cyc++;
         if (!bus.o_busy && bus.i_enable) begin
            first_pending = 1'b1;
            start_cyc = cyc;
         end
         new_wr = bus.o_wr_en && (!prev_wr || prev_acc);
         if (prev_wr && !prev_acc) chk("wr_en_held_until_ready", bus.o_wr_en, 1'b1);
         if (new_wr) begin
            chk("write_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
               chk("addr", bus.o_addr, cur.addr);
               chk("data", bus.o_data, cur.data);
               chk("wrap", bus.o_wrap, cur.wrap);
               if (first_pending) chk("first_latency", cyc - start_cyc, SD + 3);
               else chk("gap_cycles", low_cnt, cur.gap);
            end
            first_pending = 1'b0;
         end else begin
            chk("wrap_idle", bus.o_wrap, 1'b0);
            if (bus.o_wr_en && have_cur) begin
               chk("addr_stable", bus.o_addr, cur.addr);
               chk("data_stable", bus.o_data, cur.data);
            end
         end
         if (bus.o_wr_en) low_cnt = 0;
         else low_cnt++;
         prev_wr  = bus.o_wr_en;
         prev_acc = bus.o_wr_en && bus.i_ram_ready;
         if (bus.o_done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.i_enable = 1'b0;
      tick();
      chk({tag, "_wr_en"}, bus.o_wr_en, 1'b0);
      chk({tag, "_addr"}, bus.o_addr, '0);
      chk({tag, "_data"}, bus.o_data, 32'h03020100);
      chk({tag, "_count"}, bus.o_write_count, 32'd0);
      chk({tag, "_busy"}, bus.o_busy, 1'b0);
      chk({tag, "_wrap"}, bus.o_wrap, 1'b0);
      chk({tag, "_done"}, bus.o_done, 1'b0);
      rst = 1'b0;
      n_exp = 0;
   endtask

   task automatic start_burst(input int b, input int iv);
      bus.i_burst_len = 16'(b);
      bus.i_interval  = 16'(iv);
      bus.i_enable    = 1'b1;
      push_writes(b, (iv == 0) ? 1 : iv);
      done_exp++;
   endtask

   task automatic wait_done(input int budget, input bit rnd);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         bus.i_ram_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (bus.o_done) begin
            seen = 1'b1;
            bus.i_enable = 1'b0;
            chk("busy_low_at_done", bus.o_busy, 1'b0);
         end
      end
      chk("done_seen", seen, 1'b1);
      tick();
      chk("done_single_cycle", bus.o_done, 1'b0);
   endtask

   task automatic quiesce(input string tag);
      chk({tag, "_count"}, bus.o_write_count, 32'(n_exp));
      chk({tag, "_pending"}, exp_q.size(), 0);
      chk({tag, "_done_total"}, done_cnt, done_exp);
   endtask

   initial begin
      bit got;
      int hi;
      int target;
      bus.i_enable = 1'b0; bus.i_interval = '0; bus.i_burst_len = '0; bus.i_ram_ready = 1'b0;
      repeat (2) tick();
      do_reset("reset");

      // Basic timing: interval 3, ready high, two writes.
      bus.i_ram_ready = 1'b1;
      start_burst(2, 3);
      wait_done(100, 1'b0);
      quiesce("basic");

      // Second write stalled for 5 cycles.
      do_reset("reset2");
      bus.i_ram_ready = 1'b1;
      start_burst(2, 3);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (bus.o_write_count == 32'd1) begin
            got = 1'b1;
            bus.i_ram_ready = 1'b0;
         end
      end
      chk("stall_first_accept", got, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (bus.o_wr_en) got = 1'b1;
      end
      chk("stall_second_issue", got, 1'b1);
      hi = 1;
      repeat (5) begin
         tick();
         if (bus.o_wr_en) hi++;
      end
      bus.i_ram_ready = 1'b1;
      tick();
      bus.i_enable = 1'b0;
      chk("stall_high_cycles", hi, 6);
      chk("stall_wr_en_low", bus.o_wr_en, 1'b0);
      chk("stall_count", bus.o_write_count, 32'd2);
      chk("stall_done", bus.o_done, 1'b1);
      tick();
      chk("stall_done_single", bus.o_done, 1'b0);
      quiesce("stall");

      // Burst of 3, then a restart continues the sequence.
      do_reset("reset3");
      start_burst(3, 1);
      wait_done(100, 1'b0);
      quiesce("burst3");
      start_burst(1, 2);
      wait_done(100, 1'b0);
      quiesce("restart");

      // Free-run past the address wrap, random backpressure.
      bus.i_burst_len = '0;
      bus.i_interval  = '0;
      bus.i_enable    = 1'b1;
      target = n_exp + 40;
      push_writes(40, 1);
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         tick();
         bus.i_ram_ready = ($urandom_range(0, 2) != 0);
         if (bus.o_write_count == 32'(target)) begin
            got = 1'b1;
            bus.i_enable = 1'b0;
         end
      end
      chk("freerun_reached", got, 1'b1);
      tick();
      chk("freerun_idle", bus.o_busy, 1'b0);
      quiesce("freerun");

      // Random bursts and intervals; crosses the data wrap.
      for (int p = 0; p < 25; p++) begin
         start_burst($urandom_range(1, 6), $urandom_range(0, 4));
         wait_done(600, 1'b1);
      end
      quiesce("random");

      // Enable dropped while a write stalls: it completes, then idle, no done.
      bus.i_ram_ready = 1'b0;
      bus.i_burst_len = '0;
      bus.i_interval  = 16'd2;
      bus.i_enable    = 1'b1;
      push_writes(1, 2);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         if (bus.o_wr_en) got = 1'b1;
      end
      chk("drop_issue", got, 1'b1);
      repeat (3) tick();
      bus.i_enable = 1'b0;
      repeat (2) tick();
      chk("drop_still_pending", bus.o_wr_en, 1'b1);
      bus.i_ram_ready = 1'b1;
      tick();
      chk("drop_accepted", bus.o_wr_en, 1'b0);
      chk("drop_idle", bus.o_busy, 1'b0);
      chk("drop_no_done", bus.o_done, 1'b0);
      repeat (6) tick();
      quiesce("drop");

      // Reset in the middle of a stalled write.
      bus.i_ram_ready = 1'b0;
      bus.i_enable    = 1'b1;
      push_writes(1, 2);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         if (bus.o_wr_en) got = 1'b1;
      end
      chk("midreset_issue", got, 1'b1);
      repeat (2) tick();
      do_reset("midreset");
      repeat (3) tick();
      chk("midreset_stays_idle", bus.o_wr_en, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
